fir_frame_buf: RTL and testbench

FIR_FRAME_BUF -- requirements
Module: fir_frame_buf

---
 rtl/fir_frame_buf.sv | 120 ++++++++++++
 tb/tb_fir_frame_buf.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_frame_buf.sv
// -----------------------------------------------------------------------------
// fir_frame_buf
//   Ping-pong frame buffer between a FIR filter and a frame consumer.
//   Filtered samples are collected into one of two banks of FRAME_LEN words.
//   A bank that has received its last sample becomes "full" and is streamed
//   out oldest-first with a valid/ready handshake.  When both banks are full,
//   incoming samples are dropped and counted.
//
// Ports
//   clk        : single clock, rising edge
//   rst        : asynchronous, active-low reset
//   fir_valid  : fir_d carries one sample this cycle
//   fir_d      : signed 16-bit filtered sample
//   out_ready  : consumer accepts out_d this cycle
//   out_valid  : out_d holds a valid frame word
//   out_d      : frame word, oldest sample first
//   out_last   : out_d is the final word of the frame
//   overflow   : sticky, set once any sample has been dropped
//   drop_cnt   : number of dropped samples, saturating at 255
// -----------------------------------------------------------------------------
module fir_frame_buf #(
   parameter int FRAME_LEN = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        fir_valid,
   input  logic [15:0] fir_d,
   input  logic        out_ready,
   output logic        out_valid,
   output logic [15:0] out_d,
   output logic        out_last,
   output logic        overflow,
   output logic [7:0]  drop_cnt
);

   localparam int               DATA_W   = 16;
   localparam int               IDX_W    = $clog2(FRAME_LEN);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

   // Both banks live in one array; the bank number is the address MSB.
   logic signed [DATA_W-1:0] mem [2*FRAME_LEN];

   logic [1:0]       full;
   logic             wb;
   logic             rb;
   logic [IDX_W-1:0] widx;
   logic [IDX_W-1:0] ridx;

   logic             wr_en;
   logic             wr_drop;
   logic             rd_acc;
   logic [1:0]       full_set;
   logic [1:0]       full_clr;

   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   // Full flag of the write bank is sampled at the cycle start, so a sample
   // arriving while that bank's last word is being read is still dropped.
   assign wr_en     = fir_valid & ~full[wb];
   assign wr_drop   = fir_valid &  full[wb];

   assign out_valid = full[rb];
   assign out_d     = mem[{rb, ridx}];
   assign out_last  = out_valid & (ridx == LAST_IDX);
   assign rd_acc    = out_valid & out_ready;

   // A bank can only be set while empty and only be cleared while full, so
   // set and clear never target the same bank in one cycle.
   assign full_set[0] = wr_en  & (widx == LAST_IDX) & ~wb;
   assign full_set[1] = wr_en  & (widx == LAST_IDX) &  wb;
   assign full_clr[0] = rd_acc & out_last & ~rb;
   assign full_clr[1] = rd_acc & out_last &  rb;

   // Sample storage: data only, no reset.
   always_ff @(posedge clk) begin
      if (rst && wr_en)
         mem[{wb, widx}] <= fir_d;
   end

   // Control state.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         full     <= 2'b00;
         wb       <= 1'b0;
         rb       <= 1'b0;
         widx     <= '0;
         ridx     <= '0;
         overflow <= 1'b0;
         drop_cnt <= 8'd0;
      end else begin
         full <= (full | full_set) & ~full_clr;

         if (wr_en) begin
            if (widx == LAST_IDX) begin
               widx <= '0;
               wb   <= ~wb;
            end else begin
               widx <= widx + IDX_W'(1);
            end
         end

         if (wr_drop) begin
            overflow <= 1'b1;
            drop_cnt <= sat_inc8(drop_cnt);
         end

         if (rd_acc) begin
            if (out_last) begin
               ridx <= '0;
               rb   <= ~rb;
            end else begin
               ridx <= ridx + IDX_W'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_fir_frame_buf.sv
// -----------------------------------------------------------------------------
// tb_fir_frame_buf
//   Self-checking bench for fir_frame_buf (FRAME_LEN = 16).  The reference
//   model treats the buffer as a queue of completed frame words plus a queue
//   of samples collecting into the next frame; a sample is dropped when two
//   complete frames are already waiting.
// -----------------------------------------------------------------------------
module tb_fir_frame_buf;

   localparam int FL = 16;

   logic        clk = 1'b0;
   logic        rst;
   logic        fir_valid;
   logic [15:0] fir_d;
   logic        out_ready;
   logic        out_valid;
   logic [15:0] out_d;
   logic        out_last;
   logic        overflow;
   logic [7:0]  drop_cnt;

   int total = 0;
   int bad   = 0;

   // reference model state
   logic [15:0] rq[$];   // words of completed frames, oldest first
   logic [15:0] pq[$];   // samples of the frame being collected
   int          m_drops;
   bit          m_ovf;

   fir_frame_buf #(.FRAME_LEN(FL)) dut (
      .clk       (clk),
      .rst       (rst),
      .fir_valid (fir_valid),
      .fir_d     (fir_d),
      .out_ready (out_ready),
      .out_valid (out_valid),
      .out_d     (out_d),
      .out_last  (out_last),
      .overflow  (overflow),
      .drop_cnt  (drop_cnt)
   );

   always #5 clk = ~clk;

   function automatic int m_frames();
      return (rq.size() + FL - 1) / FL;
   endfunction

   function automatic bit m_valid();
      return rq.size() > 0;
   endfunction

   function automatic logic [15:0] m_d();
      return (rq.size() > 0) ? rq[0] : 16'h0000;
   endfunction

   function automatic bit m_last();
      return (rq.size() > 0) && ((rq.size() % FL) == 1);
   endfunction

   task automatic model_reset();
      rq.delete();
      pq.delete();
      m_drops = 0;
      m_ovf   = 1'b0;
   endtask

   task automatic model_step(input bit v, input logic [15:0] d, input bit r);
      bit acc;
      acc = (rq.size() > 0) && r;
      if (v) begin
         if (m_frames() == 2) begin
            m_ovf = 1'b1;
            if (m_drops < 255) m_drops++;
         end else begin
            pq.push_back(d);
         end
      end
      if (acc) void'(rq.pop_front());
      if (pq.size() == FL) begin
         foreach (pq[i]) rq.push_back(pq[i]);
         pq.delete();
      end
   endtask

   // Called at a falling edge; returns at the next falling edge.
   task automatic step(input bit v, input logic [15:0] d, input bit r);
      fir_valid = v;
      fir_d     = d;
      out_ready = r;
      @(posedge clk);
      model_step(v, d, r);
      @(negedge clk);
   endtask

   // Reset with active inputs, which must be ignored.
   task automatic do_reset();
      fir_valid = 1'b1;
      out_ready = 1'b1;
      fir_d     = 16'h1234;
      rst       = 1'b0;
      model_reset();
      repeat (3) @(negedge clk);
      rst       = 1'b1;
      fir_valid = 1'b0;
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b0; fir_valid = 1'b1; out_ready = 1'b1; fir_d = 16'h5555;
      model_reset();
      repeat (3) @(negedge clk);
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b exp=0", out_valid); end
      total++; if (out_last !== 1'b0) begin bad++; $display("FAIL rst_last got=%b exp=0", out_last); end
      total++; if (overflow !== 1'b0) begin bad++; $display("FAIL rst_ovf got=%b exp=0", overflow); end
      total++; if (drop_cnt !== 8'd0) begin bad++; $display("FAIL rst_drop got=%0d exp=0", drop_cnt); end
      rst = 1'b1; fir_valid = 1'b0; out_ready = 1'b0;
      repeat (2) step(1'b0, 16'h0, 1'b1);
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_idle_valid got=%b exp=0", out_valid); end
   endtask

   task automatic test_single_frame();
      do_reset();
      for (int i = 1; i <= FL; i++) begin
         total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL sf_early_valid i=%0d got=%b exp=0", i, out_valid); end
         step(1'b1, 16'(i), 1'b1);
      end
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL sf_latency got=%b exp=1", out_valid); end
      for (int i = 0; i < FL; i++) begin
         total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL sf_valid i=%0d got=%b exp=1", i, out_valid); end
         total++; if (out_d !== 16'(i + 1)) begin bad++; $display("FAIL sf_data i=%0d got=%0d exp=%0d", i, out_d, i + 1); end
         total++; if (out_last !== (i == FL - 1)) begin bad++; $display("FAIL sf_last i=%0d got=%b exp=%b", i, out_last, i == FL - 1); end
         step(1'b0, 16'h0, 1'b1);
      end
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL sf_end_valid got=%b exp=0", out_valid); end
   endtask

   task automatic test_two_frames();
      do_reset();
      for (int i = 1; i <= 2 * FL; i++) step(1'b1, 16'(i), 1'b0);
      total++; if (overflow !== 1'b0) begin bad++; $display("FAIL tf_ovf got=%b exp=0", overflow); end
      for (int i = 0; i < 2 * FL; i++) begin
         total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL tf_gap i=%0d got=%b exp=1", i, out_valid); end
         total++; if (out_d !== 16'(i + 1)) begin bad++; $display("FAIL tf_data i=%0d got=%0d exp=%0d", i, out_d, i + 1); end
         total++; if (out_last !== ((i % FL) == FL - 1)) begin bad++; $display("FAIL tf_last i=%0d got=%b", i, out_last); end
         step(1'b0, 16'h0, 1'b1);
      end
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL tf_end_valid got=%b exp=0", out_valid); end
   endtask

   task automatic test_overflow();
      do_reset();
      for (int i = 1; i <= 40; i++) step(1'b1, 16'(i), 1'b0);
      total++; if (overflow !== 1'b1) begin bad++; $display("FAIL of_ovf got=%b exp=1", overflow); end
      total++; if (drop_cnt !== 8'd8) begin bad++; $display("FAIL of_drop got=%0d exp=8", drop_cnt); end
      for (int i = 0; i < 2 * FL; i++) begin
         total++; if (out_d !== 16'(i + 1) || out_valid !== 1'b1) begin bad++; $display("FAIL of_data i=%0d got=%0d/%b exp=%0d/1", i, out_d, out_valid, i + 1); end
         step(1'b0, 16'h0, 1'b1);
      end
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL of_end_valid got=%b exp=0", out_valid); end
   endtask

   task automatic test_saturate();
      do_reset();
      for (int i = 1; i <= 300; i++) begin
         step(1'b1, 16'(i), 1'b0);
         if (i == 100) begin
            total++; if (drop_cnt !== 8'd68) begin bad++; $display("FAIL sat_mid got=%0d exp=68", drop_cnt); end
         end
      end
      total++; if (drop_cnt !== 8'd255) begin bad++; $display("FAIL sat_drop got=%0d exp=255", drop_cnt); end
      total++; if (overflow !== 1'b1) begin bad++; $display("FAIL sat_ovf got=%b exp=1", overflow); end
   endtask

   task automatic test_collision();
      do_reset();
      for (int i = 1; i <= 2 * FL; i++) step(1'b1, 16'(i), 1'b0);
      for (int i = 0; i < FL - 1; i++) step(1'b0, 16'h0, 1'b1);
      total++; if (out_last !== 1'b1 || out_d !== 16'd16) begin bad++; $display("FAIL col_pre got=%0d/%b exp=16/1", out_d, out_last); end
      step(1'b1, 16'd500, 1'b1);
      total++; if (drop_cnt !== 8'd1) begin bad++; $display("FAIL col_drop got=%0d exp=1", drop_cnt); end
      total++; if (out_d !== 16'd17 || out_valid !== 1'b1) begin bad++; $display("FAIL col_next got=%0d/%b exp=17/1", out_d, out_valid); end
      step(1'b1, 16'd600, 1'b0);
      for (int i = 0; i < FL; i++) begin
         total++; if (out_d !== 16'(17 + i)) begin bad++; $display("FAIL col_f2 i=%0d got=%0d exp=%0d", i, out_d, 17 + i); end
         step(1'b0, 16'h0, 1'b1);
      end
      for (int i = 1; i < FL; i++) step(1'b1, 16'(600 + i), 1'b0);
      total++; if (drop_cnt !== 8'd1) begin bad++; $display("FAIL col_drop2 got=%0d exp=1", drop_cnt); end
      for (int i = 0; i < FL; i++) begin
         total++; if (out_d !== 16'(600 + i) || out_valid !== 1'b1) begin bad++; $display("FAIL col_f3 i=%0d got=%0d exp=%0d", i, out_d, 600 + i); end
         step(1'b0, 16'h0, 1'b1);
      end
   endtask

   task automatic test_stall();
      logic [15:0] exp_w[FL];
      logic [15:0] got[$];
      logic [15:0] prev_d;
      bit          r;
      int          cyc;
      do_reset();
      for (int i = 0; i < FL; i++) begin
         exp_w[i] = 16'($urandom);
         step(1'b1, exp_w[i], 1'b0);
      end
      cyc = 0;
      while (got.size() < FL && cyc < 64) begin
         r = (cyc % 2) == 0;
         prev_d = out_d;
         if (out_valid && r) got.push_back(out_d);
         step(1'b0, 16'h0, r);
         if (!r) begin
            total++; if (out_d !== prev_d) begin bad++; $display("FAIL st_hold cyc=%0d got=%h exp=%h", cyc, out_d, prev_d); end
         end
         cyc++;
      end
      total++; if (got.size() != FL) begin bad++; $display("FAIL st_count got=%0d exp=%0d", got.size(), FL); end
      for (int i = 0; i < FL && i < got.size(); i++) begin
         total++; if (got[i] !== exp_w[i]) begin bad++; $display("FAIL st_order i=%0d got=%h exp=%h", i, got[i], exp_w[i]); end
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      for (int i = 1; i <= FL + 5; i++) step(1'b1, 16'(i), 1'b0);
      for (int i = 0; i < 5; i++) begin
         total++; if (out_d !== 16'(i + 1)) begin bad++; $display("FAIL rm_pre i=%0d got=%0d exp=%0d", i, out_d, i + 1); end
         step(1'b0, 16'h0, 1'b1);
      end
      #2 rst = 1'b0;
      model_reset();
      #1;
      total++; if (out_valid !== 1'b0 || out_last !== 1'b0) begin bad++; $display("FAIL rm_async got=%b/%b exp=0/0", out_valid, out_last); end
      repeat (2) @(negedge clk);
      rst = 1'b1;
      for (int i = 0; i < FL; i++) step(1'b1, 16'(100 + i), 1'b0);
      for (int i = 0; i < FL; i++) begin
         total++; if (out_d !== 16'(100 + i) || out_valid !== 1'b1) begin bad++; $display("FAIL rm_data i=%0d got=%0d exp=%0d", i, out_d, 100 + i); end
         step(1'b0, 16'h0, 1'b1);
      end
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rm_end_valid got=%b exp=0", out_valid); end
   endtask

   task automatic test_random();
      bit          v;
      bit          r;
      logic [15:0] d;
      int          rdy_pct;
      do_reset();
      for (int c = 0; c < 3000; c++) begin
         rdy_pct = ((c / 400) % 3 == 0) ? 20 : (((c / 400) % 3 == 1) ? 60 : 95);
         v = ($urandom_range(0, 99) < 70);
         r = ($urandom_range(0, 99) < rdy_pct);
         d = 16'($urandom);
         total++; if (out_valid !== m_valid()) begin bad++; $display("FAIL rnd_valid c=%0d got=%b exp=%b", c, out_valid, m_valid()); end
         total++; if (out_last !== m_last()) begin bad++; $display("FAIL rnd_last c=%0d got=%b exp=%b", c, out_last, m_last()); end
         if (m_valid()) begin
            total++; if (out_d !== m_d()) begin bad++; $display("FAIL rnd_data c=%0d got=%h exp=%h", c, out_d, m_d()); end
         end
         total++; if (overflow !== m_ovf || drop_cnt !== 8'(m_drops)) begin bad++; $display("FAIL rnd_drop c=%0d got=%b/%0d exp=%b/%0d", c, overflow, drop_cnt, m_ovf, m_drops); end
         step(v, d, r);
      end
   endtask

   initial begin
      rst = 1'b0; fir_valid = 1'b0; out_ready = 1'b0; fir_d = 16'h0;
      @(negedge clk);
      test_reset();
      test_single_frame();
      test_two_frames();
      test_overflow();
      test_saturate();
      test_collision();
      test_stall();
      test_reset_mid();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
